pla_rom_reverse_search: RTL

- Sequential reverse-lookup engine for a combinational 6-in/48-out PLA ROM.
- Accepts a 48-bit key and a care-mask, then sweeps every ROM address.
- Reports the first address whose output word matches the key under the mask, plus the total number of matching addresses.
- Sits beside the ROM as its reader: drives the ROM inputs and samples the ROM outputs in the same cycle.

---
 rtl/pla_rom_reverse_search.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pla_rom_reverse_search.sv
`default_nettype none
//============================================================================
// Module   : pla_rom_reverse_search
// Purpose  : Reverse-lookup engine for a combinational PLA ROM. It accepts a
//            key and a care-mask, sweeps every ROM address and reports the
//            lowest address whose output word matches the key under the mask,
//            together with the number of matching addresses.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   search request valid
//   req_ready  out  engine idle, can accept a request
//   req_key    in   [DATA_W]   target output word
//   req_mask   in   [DATA_W]   care bits (1 = compare)
//   rom_addr   out  [ADDR_W]   ROM input vector
//   rom_data   in   [DATA_W]   ROM output word, combinational from rom_addr
//   rsp_valid  out  result valid
//   rsp_ready  in   result consumed
//   rsp_found  out  at least one address matched
//   rsp_addr   out  [ADDR_W]   lowest matching address (0 when not found)
//   rsp_count  out  [ADDR_W+1] number of matching addresses
// Configuration:
//   PLA_SEARCH_EARLY_EXIT_EN - when defined, the scan stops after the first
//   match and rsp_count reports 1 (found) or 0 (not found).
//============================================================================
module pla_rom_reverse_search #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_key,
  input  logic [DATA_W-1:0] req_mask,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_found,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [ADDR_W:0]   rsp_count
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   key_q, key_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                found_q, found_d;
  logic [ADDR_W-1:0]   res_addr_q, res_addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                match;

  // Only the masked bits take part in the comparison.
  assign match = (((rom_data ^ key_q) & mask_q) == '0);

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    mask_d     = mask_q;
    addr_d     = addr_q;
    found_d    = found_q;
    res_addr_d = res_addr_q;
    count_d    = count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          key_d      = req_key;
          mask_d     = req_mask;
          found_d    = 1'b0;
          res_addr_d = '0;
          count_d    = '0;
          addr_d     = '0;
          state_d    = ST_SCAN;
        end
      end

      ST_SCAN: begin
`ifdef PLA_SEARCH_EARLY_EXIT_EN
        // The hit was recorded on the previous cycle; stop here so that a
        // hit at address a becomes visible a+2 cycles after accept.
        if (found_q) begin
          state_d = ST_DONE;
        end else begin
          if (match) begin
            found_d    = 1'b1;
            res_addr_d = addr_q;
            count_d    = CNT_ONE;
          end
          if (addr_q == ADDR_LAST) begin
            state_d = ST_DONE;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end
`else
        if (match) begin
          count_d = count_q + CNT_ONE;
          if (!found_q) begin
            found_d    = 1'b1;
            res_addr_d = addr_q;
          end
        end
        // The last address ends the scan; rom_addr never wraps here.
        if (addr_q == ADDR_LAST) begin
          state_d = ST_DONE;
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
`endif
      end

      ST_DONE: begin
        if (rsp_ready) begin
          addr_d  = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      key_q      <= '0;
      mask_q     <= '0;
      addr_q     <= '0;
      found_q    <= 1'b0;
      res_addr_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      mask_q     <= mask_d;
      addr_q     <= addr_d;
      found_q    <= found_d;
      res_addr_q <= res_addr_d;
      count_q    <= count_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rom_addr  = addr_q;
  assign rsp_found = found_q;
  assign rsp_addr  = res_addr_q;
  assign rsp_count = count_q;

endmodule
`default_nettype wire
